nonce_replay_guard: RTL and testbench

//   Anti-replay tracker sitting directly downstream of nonce_gen. On request it

---
 rtl/nonce_replay_guard.sv | 118 +++++++++++
 tb/tb_nonce_replay_guard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_replay_guard.sv
// nonce_replay_guard: tracks single-use nonces captured from nonce_gen, each with a TTL,
// and accepts a checked nonce at most once before it expires.
module nonce_replay_guard #(
    parameter int DEPTH = 4,
    parameter int TW    = 16,
    parameter int TTL   = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  nonce_in,
    input  logic                         gen_ready,
    input  logic                         issue_req,
    output logic                         issue_ack,
    output logic [31:0]                  nonce_out,
    input  logic                         chk_req,
    input  logic [31:0]                  chk_nonce,
    output logic                         chk_done,
    output logic                         chk_ok,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   live_cnt,
    output logic                         full
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, RESP} state_t;

    state_t           state, state_nx;
    logic [DEPTH-1:0] valid, valid_nx, expiring;
    logic [31:0]      nonce [DEPTH];
    logic [TW-1:0]    age [DEPTH];
    logic [31:0]      key;
    logic [IW-1:0]    idx, free_idx;
    logic [CW-1:0]    cnt_nx;
    logic             ok, hit, last, chk_go, issue_go;

    // A slot in its final cycle of life is treated as already gone for matching.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--)
            if (!valid[i]) free_idx = IW'(i);
        for (int i = 0; i < DEPTH; i++)
            expiring[i] = valid[i] && age[i] == TW'(TTL-1);
    end

    assign hit      = valid[idx] && !expiring[idx] && nonce[idx] == key && key != '0;
    assign last     = idx == IW'(DEPTH-1);
    assign chk_go   = state == IDLE && chk_req;
    assign issue_go = state == IDLE && !chk_req && issue_req && gen_ready && !full && nonce_in != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (chk_go ? SCAN : issue_go ? ISSUE : IDLE) :
                   state == SCAN ? ((flush || hit || last) ? RESP : SCAN) : IDLE;
    end

    always_comb begin
        issue_ack = state == ISSUE;
        chk_done  = state == RESP;
        chk_ok    = chk_done && ok;
    end

    // Flush is applied last so it overrides issue writes and match-clears.
    always_comb begin
        valid_nx = valid & ~expiring;
        if (issue_go) valid_nx[free_idx] = 1'b1;
        if (state == SCAN && hit) valid_nx[idx] = 1'b0;
        if (flush) valid_nx = '0;
        cnt_nx = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nx = cnt_nx + CW'(valid_nx[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= '0;
            live_cnt <= '0;
            full     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                nonce[i] <= '0;
                age[i]   <= '0;
            end
        end else begin
            valid    <= valid_nx;
            live_cnt <= cnt_nx;
            full     <= cnt_nx == CW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                age[i] <= (valid[i] && valid_nx[i]) ? age[i] + 1'b1 : '0;
                if (issue_go && free_idx == IW'(i)) nonce[i] <= nonce_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key       <= '0;
            idx       <= '0;
            ok        <= 1'b0;
            nonce_out <= '0;
        end else begin
            if (chk_go) begin
                key <= chk_nonce;
                idx <= '0;
            end
            if (issue_go) nonce_out <= nonce_in;
            if (state == SCAN) begin
                ok <= !flush && hit;
                if (!(flush || hit || last)) idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nonce_replay_guard.sv
// tb_nonce_replay_guard: directed stimulus with a scoreboard queue; a negedge monitor
// compares every issue_ack / chk_done against the queued expectation.
module tb_nonce_replay_guard;
    logic        clk = 0, rst_n = 0;
    logic [31:0] nonce_in = '0, chk_nonce = '0;
    logic        gen_ready = 1'b1, issue_req = 1'b0, chk_req = 1'b0, flush = 1'b0;
    logic        issue_ack, chk_done, chk_ok, full;
    logic [31:0] nonce_out;
    logic [2:0]  live_cnt;

    nonce_replay_guard #(.DEPTH(4), .TW(16), .TTL(20)) dut (
        .clk(clk), .rst_n(rst_n), .nonce_in(nonce_in), .gen_ready(gen_ready),
        .issue_req(issue_req), .issue_ack(issue_ack), .nonce_out(nonce_out),
        .chk_req(chk_req), .chk_nonce(chk_nonce), .chk_done(chk_done), .chk_ok(chk_ok),
        .flush(flush), .live_cnt(live_cnt), .full(full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {
        bit          is_chk;
        logic [31:0] val;
        int          live;
        int          cyc;
    } exp_t;
    exp_t q[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (issue_ack || chk_done)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: issue_ack=%b chk_done=%b with nothing pending (cycle %0d)",
                         issue_ack, chk_done, cyc);
            end else begin
                e = q.pop_front();
                cmp("resp_kind", {31'b0, chk_done}, {31'b0, e.is_chk});
                if (e.is_chk) cmp("chk_ok", {31'b0, chk_ok}, e.val);
                else          cmp("nonce_out", nonce_out, e.val);
                cmp("live_cnt", {29'b0, live_cnt}, e.live);
                if (e.cyc >= 0) cmp("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_issue(input logic [31:0] v, input int live, input int c);
        q.push_back('{1'b0, v, live, c});
    endtask

    task automatic exp_chk(input bit ok, input int live, input int c);
        q.push_back('{1'b1, {31'b0, ok}, live, c});
    endtask

    task automatic wait_issue();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = issue_ack;
        end
        @(posedge clk);
        #1 issue_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: issue_ack=0 required 1");
        end
    endtask

    task automatic wait_chk();
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = chk_done;
        end
        @(posedge clk);
        #1 chk_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL chk_timeout: chk_done=0 required 1");
        end
    endtask

    task automatic issue(input logic [31:0] v, input int live);
        nonce_in  = v;
        issue_req = 1'b1;
        exp_issue(v, live, cyc + 1);
        wait_issue();
    endtask

    task automatic check(input logic [31:0] v, input bit ok, input int lat, input int live);
        chk_nonce = v;
        chk_req   = 1'b1;
        exp_chk(ok, live, cyc + lat);
        wait_chk();
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, r;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("rst_issue_ack", {31'b0, issue_ack}, 0);
        cmp("rst_chk_done", {31'b0, chk_done}, 0);
        cmp("rst_chk_ok", {31'b0, chk_ok}, 0);
        cmp("rst_nonce_out", nonce_out, 0);
        cmp("rst_live_cnt", {29'b0, live_cnt}, 0);
        cmp("rst_full", {31'b0, full}, 0);
        @(posedge clk);
        #1;

        // basic issue, consume, replay
        issue(32'hA5A5_0001, 1);
        check(32'hA5A5_0001, 1, 2, 0);
        check(32'hA5A5_0001, 0, 5, 0);

        // fill the table, hold a 5th request until a slot is consumed
        issue(32'h1111_0001, 1);
        issue(32'h2222_0001, 2);
        issue(32'h3333_0001, 3);
        issue(32'h4444_0001, 4);
        cmp("full_after_4", {31'b0, full}, 1);
        nonce_in  = 32'h5555_0001;
        issue_req = 1'b1;
        tick(2);
        cmp("held_live_cnt", {29'b0, live_cnt}, 4);
        r = cyc;
        chk_nonce = 32'h2222_0001;
        chk_req   = 1'b1;
        exp_chk(1, 3, r + 3);
        exp_issue(32'h5555_0001, 4, r + 5);
        fork
            wait_chk();
            wait_issue();
        join
        check(32'h5555_0001, 1, 3, 3);
        flush_pulse();
        cmp("flush_live_cnt", {29'b0, live_cnt}, 0);

        // expiry boundary: first scan cycle coincides with the expiring cycle
        c = cyc;
        issue(32'h1234_5678, 1);
        tick(c + 19 - cyc);
        check(32'h1234_5678, 0, 5, 0);
        c = cyc;
        issue(32'h1234_5678, 1);
        tick(c + 18 - cyc);
        check(32'h1234_5678, 1, 2, 0);

        // check has priority over a simultaneous issue
        flush_pulse();
        issue(32'hC0DE_0001, 1);
        r = cyc;
        chk_nonce = 32'hC0DE_0001;
        chk_req   = 1'b1;
        nonce_in  = 32'hBEEF_0001;
        issue_req = 1'b1;
        exp_chk(1, 0, r + 2);
        exp_issue(32'hBEEF_0001, 1, r + 4);
        fork
            wait_chk();
            wait_issue();
        join

        // zero check, flush during scan, issue blocked by gen_ready / zero nonce
        flush_pulse();
        issue(32'h7777_0001, 1);
        issue(32'h8888_0001, 2);
        check(32'h0, 0, 5, 2);
        chk_nonce = 32'h8888_0001;
        chk_req   = 1'b1;
        exp_chk(0, 0, cyc + 2);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_chk();
        gen_ready = 1'b0;
        nonce_in  = 32'h9999_0001;
        issue_req = 1'b1;
        tick(6);
        gen_ready = 1'b1;
        nonce_in  = 32'h0;
        tick(6);
        issue_req = 1'b0;
        cmp("blocked_live_cnt", {29'b0, live_cnt}, 0);

        // asynchronous reset mid-check
        issue(32'hABCD_0001, 1);
        chk_nonce = 32'hDEAD_0001;
        chk_req   = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        cmp("midrst_live_cnt", {29'b0, live_cnt}, 0);
        cmp("midrst_nonce_out", nonce_out, 0);
        cmp("midrst_chk_done", {31'b0, chk_done}, 0);
        chk_req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        cmp("postrst_live_cnt", {29'b0, live_cnt}, 0);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pending_resp: %0d responses outstanding, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
